// File: rtl/uart_di_host_if.sv
// rtl/uart_di_host_if.sv - UART byte stream and DI bus signals seen by the bridge
interface uart_di_host_if;
  logic [7:0]  rx_data;
  logic        re;
  logic        rx_error;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_read_mode;
  logic        di_read_req;
  logic        di_read;
  logic        di_write_mode;
  logic        di_write;
  logic [15:0] di_reg_datai;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy;
  logic        di_write_rdy;
  logic [15:0] di_transfer_status;
  logic        rx_overrun;

  modport master (
    input  rx_data, re, rx_error, tx_busy, di_reg_datao, di_read_rdy, di_write_rdy,
           di_transfer_status,
    output tx_data, tx_we, di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
           di_write_mode, di_write, di_reg_datai, rx_overrun
  );

  modport slave (
    output rx_data, re, rx_error, tx_busy, di_reg_datao, di_read_rdy, di_write_rdy,
           di_transfer_status,
    input  tx_data, tx_we, di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
           di_write_mode, di_write, di_reg_datai, rx_overrun
  );
endinterface

// File: rtl/uart_di_host.sv
// rtl/uart_di_host.sv - UART command-frame parser driving one DI read/write per frame
module uart_di_host #(
  parameter int RDY_TIMEOUT     = 1000,
  parameter int RX_IDLE_TIMEOUT = 50000
) (
  input logic            ifclk,
  input logic            reset,
  uart_di_host_if.master bus_io
);
  localparam int RW = $clog2(RDY_TIMEOUT + 1);
  localparam int IW = $clog2(RX_IDLE_TIMEOUT + 1);
  localparam logic [RW-1:0] RDY_LIM  = RW'(RDY_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LIM = IW'(RX_IDLE_TIMEOUT);
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_PARSE, S_DI_RDY, S_DI_STROBE, S_DI_STATUS, S_TX, S_TX_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_tmr_q, idle_tmr_d;
  logic [RW-1:0] rdy_tmr_q, rdy_tmr_d;
  logic [1:0]    tx_idx_q, tx_idx_d;
  logic [15:0]   term_sh_q, term_sh_d, data_sh_q, data_sh_d;
  logic [31:0]   reg_sh_q, reg_sh_d;
  logic [15:0]   term_q, wdata_q, rdata_q, status_q;
  logic [31:0]   reg_q;
  logic          ovr_q;

  logic        rx_ok, last_byte, rdy_match, last_tx, frame_done, rdy_abort;
  logic [31:0] reply;
  logic [1:0]  reply_idx;
  logic [7:0]  tx_byte;
  logic        tx_we_o, rd_mode_o, wr_mode_o, rd_req_o, rd_o, wr_o;
  logic [7:0]  tx_data_o;

  assign rx_ok      = bus_io.re && !bus_io.rx_error;
  assign last_byte  = is_wr_q ? (cnt_q == 4'd8) : (cnt_q == 4'd6);
  assign rdy_match  = is_wr_q ? bus_io.di_write_rdy : bus_io.di_read_rdy;
  assign last_tx    = is_wr_q ? (tx_idx_q == 2'd1) : (tx_idx_q == 2'd3);
  assign frame_done = (state_q == S_PARSE) && rx_ok && last_byte;
  assign rdy_abort  = (state_q == S_DI_RDY) && !((rdy_tmr_q != '0) && rdy_match) &&
                      (rdy_tmr_q == RDY_LIM);
  // Reply is read data then status, LSB first; a write reply skips the data half.
  assign reply      = {status_q, rdata_q};
  assign reply_idx  = is_wr_q ? (tx_idx_q + 2'd2) : tx_idx_q;
  assign tx_byte    = reply[{reply_idx, 3'b000} +: 8];

  always_comb begin
    term_sh_d = term_sh_q;
    reg_sh_d  = reg_sh_q;
    data_sh_d = data_sh_q;
    if (state_q == S_PARSE && rx_ok) begin
      case (cnt_q)
        4'd1:    term_sh_d[7:0]   = bus_io.rx_data;
        4'd2:    term_sh_d[15:8]  = bus_io.rx_data;
        4'd3:    reg_sh_d[7:0]    = bus_io.rx_data;
        4'd4:    reg_sh_d[15:8]   = bus_io.rx_data;
        4'd5:    reg_sh_d[23:16]  = bus_io.rx_data;
        4'd6:    reg_sh_d[31:24]  = bus_io.rx_data;
        4'd7:    data_sh_d[7:0]   = bus_io.rx_data;
        4'd8:    data_sh_d[15:8]  = bus_io.rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      idle_tmr_q <= '0;
      rdy_tmr_q  <= '0;
      tx_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      idle_tmr_q <= idle_tmr_d;
      rdy_tmr_q  <= rdy_tmr_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    idle_tmr_d = '0;
    rdy_tmr_d  = '0;
    tx_idx_d   = tx_idx_q;
    case (state_q)
      S_IDLE: begin
        tx_idx_d = '0;
        if (rx_ok && (bus_io.rx_data == OP_WRITE || bus_io.rx_data == OP_READ)) begin
          is_wr_d = (bus_io.rx_data == OP_WRITE);
          cnt_d   = 4'd1;
          state_d = S_PARSE;
        end
      end
      S_PARSE: begin
        if (bus_io.re && bus_io.rx_error) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus_io.re) begin
          if (last_byte) begin
            cnt_d   = '0;
            state_d = S_DI_RDY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (idle_tmr_q == IDLE_LIM) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          idle_tmr_d = idle_tmr_q + IW'(1);
        end
      end
      S_DI_RDY: begin
        if ((rdy_tmr_q != '0) && rdy_match) begin
          state_d = S_DI_STROBE;
        end else if (rdy_tmr_q == RDY_LIM) begin
          state_d = S_TX;
        end else begin
          rdy_tmr_d = rdy_tmr_q + RW'(1);
        end
      end
      S_DI_STROBE: state_d = S_DI_STATUS;
      S_DI_STATUS: state_d = S_TX;
      S_TX: begin
        if (!bus_io.tx_busy) state_d = S_TX_GAP;
      end
      S_TX_GAP: begin
        if (last_tx) begin
          tx_idx_d = '0;
          state_d  = S_IDLE;
        end else begin
          tx_idx_d = tx_idx_q + 2'd1;
          state_d  = S_TX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs change only when a frame completes, so aborted frames leave them untouched.
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      term_sh_q <= '0;
      reg_sh_q  <= '0;
      data_sh_q <= '0;
      term_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      term_sh_q <= term_sh_d;
      reg_sh_q  <= reg_sh_d;
      data_sh_q <= data_sh_d;
      if (frame_done) begin
        term_q <= term_sh_d;
        reg_q  <= reg_sh_d;
        if (is_wr_q) wdata_q <= data_sh_d;
      end
      if (rdy_abort) begin
        rdata_q  <= '0;
        status_q <= 16'hFFFF;
      end
      if (state_q == S_DI_STROBE && !is_wr_q) rdata_q <= bus_io.di_reg_datao;
      if (state_q == S_DI_STATUS) status_q <= bus_io.di_transfer_status;
      ovr_q <= bus_io.re && !(state_q == S_IDLE || state_q == S_PARSE);
    end
  end

  always_comb begin
    rd_mode_o = 1'b0;
    wr_mode_o = 1'b0;
    rd_req_o  = 1'b0;
    rd_o      = 1'b0;
    wr_o      = 1'b0;
    tx_we_o   = 1'b0;
    tx_data_o = 8'h00;
    case (state_q)
      S_DI_RDY: begin
        rd_mode_o = !is_wr_q;
        wr_mode_o = is_wr_q;
        rd_req_o  = !is_wr_q && (rdy_tmr_q == '0);
      end
      S_DI_STROBE: begin
        rd_mode_o = !is_wr_q;
        wr_mode_o = is_wr_q;
        rd_o      = !is_wr_q;
        wr_o      = is_wr_q;
      end
      S_DI_STATUS: begin
        rd_mode_o = !is_wr_q;
        wr_mode_o = is_wr_q;
      end
      S_TX: begin
        tx_we_o   = !bus_io.tx_busy;
        tx_data_o = bus_io.tx_busy ? 8'h00 : tx_byte;
      end
      default: ;
    endcase
  end

  assign bus_io.tx_data       = tx_data_o;
  assign bus_io.tx_we         = tx_we_o;
  assign bus_io.di_term_addr  = term_q;
  assign bus_io.di_reg_addr   = reg_q;
  assign bus_io.di_reg_datai  = wdata_q;
  assign bus_io.di_read_mode  = rd_mode_o;
  assign bus_io.di_read_req   = rd_req_o;
  assign bus_io.di_read       = rd_o;
  assign bus_io.di_write_mode = wr_mode_o;
  assign bus_io.di_write      = wr_o;
  assign bus_io.rx_overrun    = ovr_q;
endmodule
